ofifo: RTL and testbench

- Output-side collection buffer for the systolic array. It is the drain counterpart of the L0 input buffer.
- Each PE-array column delivers its psum results on its own per-column valid. Because the array is skewed, columns become valid one cycle apart.
- ofifo queues each column independently and presents the results downstream only as aligned full rows. Each accepted read pops one entry from every column at once; the popped row then goes to output SRAM.

---
 rtl/ofifo.sv | 105 ++++++++++
 tb/tb_ofifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ofifo.sv
// Output collection buffer for the systolic array: one circular queue per column,
// popped together as aligned rows once every column holds at least one entry.
module ofifo #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_out_valid,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_overflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [bw-1:0]        mem_q [col][depth];
  logic [col-1:0][AW:0] wptr_q, wptr_d;
  // All columns pop together, so a single read pointer serves every lane.
  logic [AW:0]          rptr_q, rptr_d;
  logic [col*bw-1:0]    out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overflow_q, overflow_d;
  logic [col-1:0]       empty, full, wen;
  logic                 pop;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < col; i++) begin
      empty[i] = (wptr_q[i] == rptr_q);
      full[i]  = (wptr_q[i][AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[i][AW] != rptr_q[AW]);
    end
  end

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    wen         = '0;
    for (int i = 0; i < col; i++) begin
      if (wr[i] && !full[i]) begin
        wen[i]    = 1'b1;
        wptr_d[i] = wptr_q[i] + PTR_ONE;
      end else if (wr[i]) begin
        overflow_d = 1'b1;
      end else begin
        wen[i] = 1'b0;
      end
    end
    if (pop) begin
      rptr_d      = rptr_q + PTR_ONE;
      out_valid_d = 1'b1;
      for (int i = 0; i < col; i++) begin
        out_d[i*bw +: bw] = mem_q[i][rptr_q[AW-1:0]];
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only reachable through the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wen[i]) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= in[i*bw +: bw];
      end
    end
  end

  assign out         = out_q;
  assign o_out_valid = out_valid_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_ofifo.sv
// Directed self-checking bench for ofifo (col=8, bw=16, depth=64).
module tb_ofifo;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic [7:0]   wr;
  logic         rd;
  logic [W-1:0] out;
  logic         o_out_valid, o_valid, o_full, o_ready, o_overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  ofifo dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_out_valid(o_out_valid), .o_valid(o_valid), .o_full(o_full),
    .o_ready(o_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk_row(input logic [7:0] lo);
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = {8'(i), lo};
    return r;
  endfunction

  function automatic logic [W-1:0] stream(input int n);
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = {4'(i), 12'(n)};
    return r;
  endfunction

  task automatic test_reset;
    reset = 1'b0; wr = 8'hFF; rd = 1'b1; in = stream(5);
    tick; tick;
    total_cnt++;
    if (out !== 128'd0) $display("FAIL reset_out got=%h exp=0", out);
    else pass_cnt++;
    total_cnt++;
    if ({o_out_valid, o_valid, o_full, o_ready, o_overflow} !== 5'b00010)
      $display("FAIL reset_status got=%b exp=00010", {o_out_valid, o_valid, o_full, o_ready, o_overflow});
    else pass_cnt++;
    reset = 1'b1; wr = 8'h00; rd = 1'b0;
  endtask

  task automatic test_skewed_fill;
    logic [W-1:0] d;
    logic [7:0]   w;
    for (int c = 0; c < 11; c++) begin
      for (int i = 0; i < 8; i++) begin
        w[i] = (c >= i) && (c < i + 4);
        d[i*16 +: 16] = {8'(i), 8'(c - i)};
      end
      wr = w; in = d;
      tick;
      total_cnt++;
      if (o_valid !== (c >= 7)) $display("FAIL skew_valid c=%0d got=%b exp=%b", c, o_valid, (c >= 7));
      else pass_cnt++;
    end
    wr = 8'h00;
    for (int k = 0; k < 4; k++) begin
      rd = 1'b1; tick;
      total_cnt++;
      if ({o_out_valid, out} !== {1'b1, mk_row(8'(k))})
        $display("FAIL skew_row k=%0d got=%b/%h exp=1/%h", k, o_out_valid, out, mk_row(8'(k)));
      else pass_cnt++;
      rd = 1'b0; tick;
      total_cnt++;
      if ({o_out_valid, out} !== {1'b0, mk_row(8'(k))})
        $display("FAIL skew_hold k=%0d got=%b/%h exp=0/%h", k, o_out_valid, out, mk_row(8'(k)));
      else pass_cnt++;
    end
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL skew_empty got=%b exp=0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    wr = 8'h01;
    for (int j = 0; j < 64; j++) begin
      in = stream(j);
      tick;
      if (j == 62) begin
        total_cnt++;
        if ({o_full, o_ready} !== 2'b01) $display("FAIL ovf_63 got=%b exp=01", {o_full, o_ready});
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({o_full, o_ready, o_overflow, o_valid} !== 4'b1000)
      $display("FAIL ovf_full got=%b exp=1000", {o_full, o_ready, o_overflow, o_valid});
    else pass_cnt++;
    in = {112'd0, 16'hDEAD};
    tick;
    total_cnt++;
    if ({o_full, o_ready, o_overflow, o_valid} !== 4'b1010)
      $display("FAIL ovf_drop got=%b exp=1010", {o_full, o_ready, o_overflow, o_valid});
    else pass_cnt++;
    wr = 8'h00; rd = 1'b1;
    tick;
    total_cnt++;
    if (o_out_valid !== 1'b0) $display("FAIL ovf_noread got=%b exp=0", o_out_valid);
    else pass_cnt++;
    rd = 1'b0; reset = 1'b0;
    tick;
    reset = 1'b1;
    total_cnt++;
    if ({out, o_out_valid, o_valid, o_full, o_ready, o_overflow} !== {128'd0, 5'b00010})
      $display("FAIL ovf_clear got=%h/%b exp=0/00010", out, {o_out_valid, o_valid, o_full, o_ready, o_overflow});
    else pass_cnt++;
  endtask

  task automatic test_streaming;
    wr = 8'hFF; rd = 1'b0; in = stream(0);
    tick;
    rd = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      in = stream(n);
      tick;
      total_cnt++;
      if ({out, o_out_valid, o_valid, o_full, o_ready, o_overflow} !== {stream(n - 1), 5'b11010})
        $display("FAIL stream n=%0d got=%h/%b exp=%h/11010", n, out,
                 {o_out_valid, o_valid, o_full, o_ready, o_overflow}, stream(n - 1));
      else pass_cnt++;
    end
    wr = 8'h00;
    tick;
    rd = 1'b0;
    total_cnt++;
    if ({out, o_out_valid, o_valid} !== {stream(260), 2'b10})
      $display("FAIL stream_drain got=%h/%b exp=%h/10", out, {o_out_valid, o_valid}, stream(260));
    else pass_cnt++;
  endtask

  task automatic test_empty_column;
    wr = 8'hF7;
    for (int k = 0; k < 2; k++) begin
      in = mk_row(8'(8'h50 + k));
      tick;
    end
    wr = 8'h00; rd = 1'b1;
    tick;
    rd = 1'b0;
    total_cnt++;
    if ({out, o_out_valid, o_valid} !== {stream(260), 2'b00})
      $display("FAIL hole_noread got=%h/%b exp=%h/00", out, {o_out_valid, o_valid}, stream(260));
    else pass_cnt++;
    wr = 8'h08; in = mk_row(8'h50);
    #1;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL hole_sameclk got=%b exp=0", o_valid);
    else pass_cnt++;
    tick;
    wr = 8'h00;
    total_cnt++;
    if (o_valid !== 1'b1) $display("FAIL hole_filled got=%b exp=1", o_valid);
    else pass_cnt++;
    rd = 1'b1;
    tick;
    rd = 1'b0;
    total_cnt++;
    if ({out, o_out_valid} !== {mk_row(8'h50), 1'b1})
      $display("FAIL hole_row got=%h/%b exp=%h/1", out, o_out_valid, mk_row(8'h50));
    else pass_cnt++;
    tick;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL hole_after got=%b exp=0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    wr = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      in = mk_row(8'(8'h60 + k));
      tick;
    end
    wr = 8'h00; rd = 1'b1; reset = 1'b0;
    tick;
    reset = 1'b1; rd = 1'b0;
    total_cnt++;
    if ({out, o_out_valid, o_valid, o_full, o_ready, o_overflow} !== {128'd0, 5'b00010})
      $display("FAIL midrst got=%h/%b exp=0/00010", out, {o_out_valid, o_valid, o_full, o_ready, o_overflow});
    else pass_cnt++;
    wr = 8'hFF; in = mk_row(8'h77);
    tick;
    wr = 8'h00; rd = 1'b1;
    tick;
    rd = 1'b0;
    total_cnt++;
    if ({out, o_out_valid} !== {mk_row(8'h77), 1'b1})
      $display("FAIL midrst_fresh got=%h/%b exp=%h/1", out, o_out_valid, mk_row(8'h77));
    else pass_cnt++;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL midrst_empty got=%b exp=0", o_valid);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0; wr = 8'h00; rd = 1'b0; in = '0;
    test_reset;
    test_skewed_fill;
    test_overflow;
    test_streaming;
    test_empty_column;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
